// File: rtl/count_seq_ctrl_if.sv
// Handshake bundle between the step sequencer, its table-programming source and the counter.
interface count_seq_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [6:0] wr_data;
    logic       start;
    logic       abort;
    logic [6:0] count_in;
    logic [6:0] max_count;
    logic       run;
    logic [1:0] step;
    logic       busy;
    logic       step_done;
    logic       seq_done;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort, count_in,
        input  max_count, run, step, busy, step_done, seq_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort, count_in,
        output max_count, run, step, busy, step_done, seq_done
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Walks a programmable up-counter through up to four target counts, dwelling at each; all outputs registered.
// Define SEQ_LOOP_EN to restart at step 0 after the last step instead of returning to idle.
module count_seq_ctrl #(
    parameter int NUM_STEPS = 4,
    parameter int DWELL     = 3
) (
    input  logic              CLK,
    input  logic              reset,
    count_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_DWELL
    } state_t;

    localparam logic [1:0] LAST_STEP  = 2'(NUM_STEPS - 1);
    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
    localparam logic [6:0] MAX_TARGET = 7'd99;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [3:0] dwell_q, dwell_d;
    logic [6:0] tbl [4];

    logic       step_done_d, seq_done_d;
    logic       run_d, busy_d;
    logic [6:0] max_count_d;

    logic [6:0] max_count_q;
    logic       run_q, busy_q, step_done_q, seq_done_q;

    logic       wr_accept;
    logic [6:0] wr_clamped;
    logic [6:0] target;

    assign wr_accept  = bus.wr_en && (state_q == S_IDLE);
    assign wr_clamped = (bus.wr_data > MAX_TARGET) ? MAX_TARGET : bus.wr_data;
    assign target     = tbl[step_q];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_accept) begin
            tbl[bus.wr_addr] <= wr_clamped;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        step_done_d = 1'b0;
        seq_done_d  = 1'b0;

        // abort overrides every transition and suppresses both pulses
        if (bus.abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_CLEAR;
                        step_d  = '0;
                    end
                end
                S_CLEAR: begin
                    state_d = S_COUNT;
                end
                S_COUNT: begin
                    if (bus.count_in == target) begin
                        state_d     = S_DWELL;
                        dwell_d     = '0;
                        step_done_d = 1'b1;
                    end
                end
                S_DWELL: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (step_q < LAST_STEP) begin
                            step_d  = step_q + 2'd1;
                            state_d = S_CLEAR;
                        end else begin
                            seq_done_d = 1'b1;
                            step_d     = '0;
`ifdef SEQ_LOOP_EN
                            state_d    = S_CLEAR;
`else
                            state_d    = S_IDLE;
`endif
                        end
                    end else begin
                        dwell_d = dwell_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered copies of what the next state implies
    always_comb begin
        run_d       = (state_d == S_COUNT) || (state_d == S_DWELL);
        busy_d      = (state_d != S_IDLE);
        max_count_d = (state_d == S_IDLE) ? 7'd0 : tbl[step_d];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            max_count_q <= '0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            max_count_q <= max_count_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign bus.max_count = max_count_q;
    assign bus.run       = run_q;
    assign bus.step      = step_q;
    assign bus.busy      = busy_q;
    assign bus.step_done = step_done_q;
    assign bus.seq_done  = seq_done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural model of the programmable counter.
module tb_count_seq_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic [6:0] cnt;
    int         n_checks = 0;
    int         n_errors = 0;

    int sd_cyc[$];
    int sd_cnt[$];
    int sd_step[$];
    int sd_max[$];
    int rl_cyc[$];
    int sq_cyc[$];
    int bl_cyc[$];

    count_seq_ctrl_if bus ();

    count_seq_ctrl #(.NUM_STEPS(4), .DWELL(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // counter contract: run=0 clears, run=1 counts up to max_count and holds
    always @(posedge CLK or posedge reset) begin
        if (reset)                      cnt <= 7'd0;
        else if (!bus.run)              cnt <= 7'd0;
        else if (cnt != bus.max_count)  cnt <= cnt + 7'd1;
    end
    assign bus.count_in = cnt;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] addr, input logic [6:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_seq();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic go_idle();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
    endtask

    // records events from cycle 0 (the CLEAR cycle after start) through cycle ncyc
    task automatic run_monitor(input int ncyc);
        sd_cyc.delete(); sd_cnt.delete(); sd_step.delete(); sd_max.delete();
        rl_cyc.delete(); sq_cyc.delete(); bl_cyc.delete();
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) tick();
            if (bus.step_done) begin
                sd_cyc.push_back(k);
                sd_cnt.push_back(int'(bus.count_in));
                sd_step.push_back(int'(bus.step));
                sd_max.push_back(int'(bus.max_count));
            end
            if (bus.busy && !bus.run && !bus.seq_done) rl_cyc.push_back(k);
            if (bus.seq_done) sq_cyc.push_back(k);
            if (!bus.busy) bl_cyc.push_back(k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 7'd0;
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus.max_count, bus.run, bus.step, bus.busy, bus.step_done, bus.seq_done} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got max=%0d run=%0d step=%0d busy=%0d sd=%0d sq=%0d required all 0",
                     bus.max_count, bus.run, bus.step, bus.busy, bus.step_done, bus.seq_done);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%0d required 0", bus.busy);
        end
    endtask

    task automatic test_sequence();
        int exp_sd[4] = '{7, 22, 126, 131};
        int exp_tg[4] = '{5, 10, 99, 0};
        int exp_rl[4] = '{0, 10, 25, 129};
        write_entry(2'd0, 7'd5);
        write_entry(2'd1, 7'd10);
        write_entry(2'd2, 7'd99);
        write_entry(2'd3, 7'd0);
        start_seq();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.run !== 1'b0 || bus.max_count !== 7'd5 || bus.step !== 2'd0) begin
            n_errors++;
            $display("FAIL seq_clear_entry: busy=%0d run=%0d max=%0d step=%0d required 1 0 5 0",
                     bus.busy, bus.run, bus.max_count, bus.step);
        end
        run_monitor(134);
        n_checks++;
        if (sd_cyc.size() != 4) begin
            n_errors++;
            $display("FAIL seq_step_done_count: got %0d required 4", sd_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (sd_cyc[i] !== exp_sd[i] || sd_cnt[i] !== exp_tg[i] || sd_step[i] !== i) begin
                    n_errors++;
                    $display("FAIL seq_step_done[%0d]: cycle=%0d count=%0d step=%0d required %0d %0d %0d",
                             i, sd_cyc[i], sd_cnt[i], sd_step[i], exp_sd[i], exp_tg[i], i);
                end
            end
        end
        n_checks++;
        if (rl_cyc.size() != 4 || rl_cyc[0] !== exp_rl[0] || rl_cyc[1] !== exp_rl[1] ||
            rl_cyc[2] !== exp_rl[2] || rl_cyc[3] !== exp_rl[3]) begin
            n_errors++;
            $display("FAIL seq_run_low: got %0d low cycles required 4 at 0,10,25,129", rl_cyc.size());
        end
        n_checks++;
        if (sq_cyc.size() != 1 || sq_cyc[0] !== 134) begin
            n_errors++;
            $display("FAIL seq_done_pulse: got %0d pulses required exactly 1 at cycle 134", sq_cyc.size());
        end
`ifndef SEQ_LOOP_EN
        n_checks++;
        if (bl_cyc.size() != 1 || bl_cyc[0] !== 134 || bus.step !== 2'd0 || bus.run !== 1'b0) begin
            n_errors++;
            $display("FAIL seq_return_idle: idle cycles=%0d step=%0d run=%0d required idle only at 134",
                     bl_cyc.size(), bus.step, bus.run);
        end
`else
        n_checks++;
        if (bl_cyc.size() != 0 || bus.step !== 2'd0) begin
            n_errors++;
            $display("FAIL seq_loop_restart: idle cycles=%0d step=%0d required 0 0", bl_cyc.size(), bus.step);
        end
`endif
        go_idle();
    endtask

    task automatic test_clamp();
        write_entry(2'd0, 7'd1);
        write_entry(2'd1, 7'd120);
        write_entry(2'd2, 7'd2);
        write_entry(2'd3, 7'd3);
        start_seq();
        run_monitor(125);
        n_checks++;
        if (sd_cyc.size() != 4 || sd_cyc[1] !== 107 || sd_cnt[1] !== 99 || sd_max[1] !== 99) begin
            n_errors++;
            $display("FAIL clamp_120: pulses=%0d cycle=%0d count=%0d max=%0d required 4 107 99 99",
                     sd_cyc.size(), sd_cyc[1], sd_cnt[1], sd_max[1]);
        end
        n_checks++;
        if (sq_cyc.size() != 1 || sq_cyc[0] !== 125) begin
            n_errors++;
            $display("FAIL clamp_seq_done: pulses=%0d required 1 at cycle 125", sq_cyc.size());
        end
        go_idle();
    endtask

    task automatic test_abort();
        logic seen;
        start_seq();
        repeat (107) tick();
        n_checks++;
        if (bus.step_done !== 1'b1 || bus.step !== 2'd1) begin
            n_errors++;
            $display("FAIL abort_reach_dwell: step_done=%0d step=%0d required 1 1", bus.step_done, bus.step);
        end
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if ({bus.max_count, bus.run, bus.step, bus.busy, bus.step_done, bus.seq_done} !== 13'd0) begin
            n_errors++;
            $display("FAIL abort_to_idle: max=%0d run=%0d step=%0d busy=%0d sd=%0d sq=%0d required all 0",
                     bus.max_count, bus.run, bus.step, bus.busy, bus.step_done, bus.seq_done);
        end
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | bus.step_done | bus.seq_done | bus.busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_quiet: activity=%0d required 0", seen);
        end
        start_seq();
        n_checks++;
        if (bus.step !== 2'd0 || bus.busy !== 1'b1 || bus.run !== 1'b0 || bus.max_count !== 7'd1) begin
            n_errors++;
            $display("FAIL abort_restart: step=%0d busy=%0d run=%0d max=%0d required 0 1 0 1",
                     bus.step, bus.busy, bus.run, bus.max_count);
        end
        tick();
        n_checks++;
        if (bus.run !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_restart_run: run=%0d required 1", bus.run);
        end
        go_idle();
    endtask

    task automatic test_busy_ignore();
        write_entry(2'd0, 7'd2);
        write_entry(2'd1, 7'd1);
        write_entry(2'd2, 7'd0);
        write_entry(2'd3, 7'd1);
        start_seq();
        fork
            run_monitor(24);
            begin
                repeat (2) tick();
                bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 7'd50; bus.start = 1'b1;
                tick();
                bus.wr_en = 1'b0; bus.start = 1'b0;
                repeat (6) tick();
                bus.wr_en = 1'b1; bus.wr_data = 7'd60;
                tick();
                bus.wr_en = 1'b0;
            end
        join
        n_checks++;
        if (sd_cyc.size() != 4 || sd_cyc[0] !== 4 || sd_cyc[1] !== 10 || sd_cyc[2] !== 15 ||
            sd_cyc[3] !== 21 || sd_max[1] !== 1) begin
            n_errors++;
            $display("FAIL busy_write_dropped: pulses=%0d step1 cycle=%0d max=%0d required 4 10 1",
                     sd_cyc.size(), sd_cyc[1], sd_max[1]);
        end
        n_checks++;
        if (sq_cyc.size() != 1 || sq_cyc[0] !== 24) begin
            n_errors++;
            $display("FAIL busy_start_ignored: seq_done pulses=%0d required 1 at cycle 24", sq_cyc.size());
        end
        go_idle();
    endtask

    task automatic test_start_abort();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.run !== 1'b0) begin
            n_errors++;
            $display("FAIL start_abort_idle: busy=%0d run=%0d required 0 0", bus.busy, bus.run);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_abort_stays: busy=%0d required 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        write_entry(2'd0, 7'd40);
        start_seq();
        repeat (10) tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.run !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_count_busy: busy=%0d run=%0d required 1 1", bus.busy, bus.run);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus.max_count, bus.run, bus.step, bus.busy, bus.step_done, bus.seq_done} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: max=%0d run=%0d step=%0d busy=%0d required all 0",
                     bus.max_count, bus.run, bus.step, bus.busy);
        end
        reset = 1'b0;
        tick();
        start_seq();
        run_monitor(20);
        n_checks++;
        if (sd_cyc.size() != 4 || sd_cyc[0] !== 2 || sd_cyc[1] !== 7 || sd_cyc[2] !== 12 ||
            sd_cyc[3] !== 17 || sd_max[0] !== 0 || sd_max[1] !== 0 || sd_max[2] !== 0 || sd_max[3] !== 0) begin
            n_errors++;
            $display("FAIL reset_table_cleared: pulses=%0d first cycle=%0d first max=%0d required 4 2 0",
                     sd_cyc.size(), sd_cyc[0], sd_max[0]);
        end
        n_checks++;
        if (sq_cyc.size() != 1 || sq_cyc[0] !== 20) begin
            n_errors++;
            $display("FAIL reset_zero_seq_done: pulses=%0d required 1 at cycle 20", sq_cyc.size());
        end
        go_idle();
    endtask

`ifdef SEQ_LOOP_EN
    task automatic test_loop();
        int exp_step[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        write_entry(2'd0, 7'd2);
        write_entry(2'd1, 7'd3);
        write_entry(2'd2, 7'd1);
        write_entry(2'd3, 7'd4);
        start_seq();
        run_monitor(60);
        n_checks++;
        if (sq_cyc.size() != 2 || sq_cyc[0] !== 30 || sq_cyc[1] !== 60 || bl_cyc.size() != 0) begin
            n_errors++;
            $display("FAIL loop_passes: seq_done=%0d idle cycles=%0d required 2 at 30,60 and 0",
                     sq_cyc.size(), bl_cyc.size());
        end
        n_checks++;
        if (sd_step.size() != 8) begin
            n_errors++;
            $display("FAIL loop_step_count: got %0d required 8", sd_step.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sd_step[i] !== exp_step[i]) begin
                    n_errors++;
                    $display("FAIL loop_step_wrap[%0d]: step=%0d required %0d", i, sd_step[i], exp_step[i]);
                end
            end
        end
        go_idle();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL loop_abort: busy=%0d required 0", bus.busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_clamp();
        test_abort();
        test_busy_ignore();
        test_start_abort();
        test_reset_mid();
`ifdef SEQ_LOOP_EN
        test_loop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
